// File: rtl/pi1_pkg.sv
// Shared PerInt (pi1) definitions: op encodings, fabric FSM states and clog2.
package pi1_pkg;

    localparam logic [1:0] PINOOP = 2'd0;
    localparam logic [1:0] PIWROP = 2'd1;
    localparam logic [1:0] PIRDOP = 2'd2;
    localparam logic [1:0] PIRWOP = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } pi1_state_e;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/pi1r_rrpick.sv
// Combinational round-robin picker: first requesting index strictly after last_i.
module pi1r_rrpick #(
    parameter int N    = 2,
    parameter int IDXW = 1
) (
    input  logic [N-1:0]    req_i,
    input  logic [IDXW-1:0] last_i,
    output logic [IDXW-1:0] win_o,
    output logic            vld_o
);

    int idx;

    always_comb begin
        win_o = '0;
        vld_o = 1'b0;
        idx   = 0;
        // Walk last+1 .. last+N so last_i itself is considered only after everyone else.
        for (int k = 1; k <= N; k++) begin
            idx = (int'(last_i) + k) % N;
            if (!vld_o && req_i[idx]) begin
                vld_o = 1'b1;
                win_o = IDXW'(idx);
            end
        end
    end

endmodule

// File: rtl/pi1r.sv
// N-master to 1-slave pi1 interconnect with round-robin arbitration and registered slave side.
// Optional bus lock for atomic sequences is enabled by defining PI1R_LOCK_EN.
module pi1r
    import pi1_pkg::*;
#(
    parameter  int MASTERCOUNT = 2,
    parameter  int ARCHBITSZ   = 32,
    localparam int ADDRBITSZ   = ARCHBITSZ - clog2(ARCHBITSZ / 8),
    localparam int SELW        = ARCHBITSZ / 8,
    localparam int IDXW        = (MASTERCOUNT > 1) ? clog2(MASTERCOUNT) : 1
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic [2*MASTERCOUNT-1:0]         m_op_i,
    input  logic [ADDRBITSZ*MASTERCOUNT-1:0] m_addr_i,
    input  logic [ARCHBITSZ*MASTERCOUNT-1:0] m_data_i,
    input  logic [SELW*MASTERCOUNT-1:0]      m_sel_i,
`ifdef PI1R_LOCK_EN
    input  logic [MASTERCOUNT-1:0]           m_lock_i,
`endif
    output logic [ARCHBITSZ-1:0]             m_data_o,
    output logic [MASTERCOUNT-1:0]           m_rdy_o,
    output logic [1:0]                       s_op_o,
    output logic [ADDRBITSZ-1:0]             s_addr_o,
    output logic [ARCHBITSZ-1:0]             s_data_o,
    output logic [SELW-1:0]                  s_sel_o,
    input  logic [ARCHBITSZ-1:0]             s_data_i,
    input  logic                             s_rdy_i
);

    pi1_state_e               state_q, state_d;
    logic [IDXW-1:0]          last_q, last_d;
    logic [IDXW-1:0]          gnt_q, gnt_d;
    logic [1:0]               s_op_q, s_op_d;
    logic [ADDRBITSZ-1:0]     s_addr_q, s_addr_d;
    logic [ARCHBITSZ-1:0]     s_data_q, s_data_d;
    logic [SELW-1:0]          s_sel_q, s_sel_d;
    logic [ARCHBITSZ-1:0]     m_data_q, m_data_d;
    logic [MASTERCOUNT-1:0]   m_rdy_q, m_rdy_d;

    logic [MASTERCOUNT-1:0]   req, pick_req, gnt_oh;
    logic [IDXW-1:0]          pick_win;
    logic                     pick_vld;
    int                       win_idx;

    always_comb begin
        req    = '0;
        gnt_oh = '0;
        for (int i = 0; i < MASTERCOUNT; i++) begin
            req[i]    = (m_op_i[2*i +: 2] != PINOOP);
            gnt_oh[i] = (gnt_q == IDXW'(i));
        end
    end

`ifdef PI1R_LOCK_EN
    logic lock_q, lock_d;
    logic lock_eff;

    // The lock is released in the same IDLE cycle the owner drops m_lock_i.
    assign lock_eff = lock_q && m_lock_i[gnt_q];
    assign pick_req = lock_eff ? (req & gnt_oh) : req;
`else
    assign pick_req = req;
`endif

    pi1r_rrpick #(
        .N    (MASTERCOUNT),
        .IDXW (IDXW)
    ) u_pick (
        .req_i  (pick_req),
        .last_i (last_q),
        .win_o  (pick_win),
        .vld_o  (pick_vld)
    );

    assign win_idx = int'(pick_win);

    always_comb begin
        state_d  = state_q;
        last_d   = last_q;
        gnt_d    = gnt_q;
        s_op_d   = s_op_q;
        s_addr_d = s_addr_q;
        s_data_d = s_data_q;
        s_sel_d  = s_sel_q;
        m_data_d = m_data_q;
        m_rdy_d  = '0;
`ifdef PI1R_LOCK_EN
        lock_d   = lock_q;
`endif
        case (state_q)
            ST_IDLE: begin
`ifdef PI1R_LOCK_EN
                lock_d = lock_eff;
`endif
                if (pick_vld) begin
                    state_d  = ST_BUSY;
                    last_d   = pick_win;
                    gnt_d    = pick_win;
                    s_op_d   = m_op_i[2*win_idx +: 2];
                    s_addr_d = m_addr_i[ADDRBITSZ*win_idx +: ADDRBITSZ];
                    s_data_d = m_data_i[ARCHBITSZ*win_idx +: ARCHBITSZ];
                    s_sel_d  = m_sel_i[SELW*win_idx +: SELW];
                end
            end
            ST_BUSY: begin
                if (s_rdy_i) begin
                    state_d  = ST_RESP;
                    s_op_d   = PINOOP;
                    m_data_d = s_data_i;
                    m_rdy_d  = gnt_oh;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
`ifdef PI1R_LOCK_EN
                lock_d  = m_lock_i[gnt_q];
`endif
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q  <= ST_IDLE;
            last_q   <= IDXW'(MASTERCOUNT - 1);
            gnt_q    <= '0;
            s_op_q   <= PINOOP;
            s_addr_q <= '0;
            s_data_q <= '0;
            s_sel_q  <= '0;
            m_data_q <= '0;
            m_rdy_q  <= '0;
`ifdef PI1R_LOCK_EN
            lock_q   <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            gnt_q    <= gnt_d;
            s_op_q   <= s_op_d;
            s_addr_q <= s_addr_d;
            s_data_q <= s_data_d;
            s_sel_q  <= s_sel_d;
            m_data_q <= m_data_d;
            m_rdy_q  <= m_rdy_d;
`ifdef PI1R_LOCK_EN
            lock_q   <= lock_d;
`endif
        end
    end

    assign m_data_o = m_data_q;
    assign m_rdy_o  = m_rdy_q;
    assign s_op_o   = s_op_q;
    assign s_addr_o = s_addr_q;
    assign s_data_o = s_data_q;
    assign s_sel_o  = s_sel_q;

endmodule

// File: doc/pi1r.md
# pi1r

Parametrised N-master to 1-slave PerInt (pi1) interconnect with registered slave-side request, round-robin arbitration and per-master response routing. It is the single-clock successor to the single-master pi1 bridge. It sits between the PU array of a multi-core cpu and the memory/peripheral slave, and replaces the bridge when cores and memory share one clock. Optionally, a master can lock the bus across back-to-back transactions for atomic sequences.

## Interface
- MASTERCOUNT, 2: number of masters; must be ≥1.
- ARCHBITSZ, 32: data width; must be a power of two and ≥16.
- ADDRBITSZ (local), ARCHBITSZ-clog2(ARCHBITSZ/8): word address width.

- clk_i  in  1  clock; all state on rising edge.
- rst_i  in  1  reset; **asynchronous and active-low**.
- m_op_i  in  2*MASTERCOUNT  per-master op; slice i is [2*i+1:2*i].
- m_addr_i  in  ADDRBITSZ*MASTERCOUNT  per-master word address.
- m_data_i  in  ARCHBITSZ*MASTERCOUNT  per-master write data.
- m_sel_i  in  (ARCHBITSZ/8)*MASTERCOUNT  per-master byte select.
- m_lock_i  in  MASTERCOUNT  per-master lock request; present only with PI1R_LOCK_EN.
- m_data_o  out  ARCHBITSZ  read data; shared by all masters; valid only with that master's m_rdy_o bit.
- m_rdy_o  out  MASTERCOUNT  one-hot completion pulse.
- s_op_o  out  2  registered slave op.
- s_addr_o  out  ADDRBITSZ  registered slave address.
- s_data_o  out  ARCHBITSZ  registered slave write data.
- s_sel_o  out  ARCHBITSZ/8  registered slave byte select.
- s_data_i  in  ARCHBITSZ  slave read data; valid when s_rdy_i is high.
- s_rdy_i  in  1  slave completion.

## Operation
- Ops: PINOOP=0, PIWROP=1, PIRDOP=2, PIRWOP=3 (swap: write and return old data). A master requests whenever its op is not PINOOP.
- Master rule: hold op, addr, data and sel stable from issue until the cycle its m_rdy_o bit is high. The op may change in the following cycle.
- FSM, 2-bit state:
  - IDLE: if any master requests, pick a winner, latch its op/addr/data/sel into the s_* registers and go to BUSY. Otherwise s_op_o=PINOOP.
  - BUSY: hold the s_* registers. When s_rdy_i=1, latch s_data_i into m_data_o, set s_op_o=PINOOP and go to RESP.
  - RESP: assert m_rdy_o[gnt] for exactly this cycle, then go to IDLE.
- Round-robin: a pointer `last` holds the last-served index. The winner is the first requesting index strictly after `last`, modulo MASTERCOUNT. `last` updates to the winner on the IDLE→BUSY transition.
- m_data_o is updated for every op, including PIWROP. Masters ignore it on writes.
- If requests are simultaneous, exactly one master is granted. The others wait with no side effect.
- MASTERCOUNT=1: the picker degenerates to "request present". Behaviour is otherwise identical.
- Reset is async and may occur mid-transaction:
  - Outputs go to reset values immediately, so s_op_o drops to PINOOP.
  - The in-flight transaction is abandoned. The slave must tolerate a dropped op.

## Timing
- Reset values: s_op_o=0, s_addr_o=0, s_data_o=0, s_sel_o=0, m_data_o=0, m_rdy_o=0, state=IDLE, last=MASTERCOUNT-1 so master 0 wins first, lock=0.
- Request seen in cycle t (IDLE) → s_op_o valid at t+1.
- s_rdy_i high in cycle k → m_rdy_o pulse and m_data_o valid at k+1.
- Minimum turnaround is 3 cycles per transaction. s_rdy_i in the first BUSY cycle gives m_rdy_o at t+2 and the next grant decision at t+3.
- s_rdy_i is ignored in IDLE and RESP.
- There is no timeout. A slave that never asserts s_rdy_i stalls the fabric.

## Configuration
- PI1R_LOCK_EN defined:
  - m_lock_i exists.
  - In RESP, if m_lock_i[gnt]=1, a lock flag is set. While the flag is set, IDLE grants only master gnt and other requests wait.
  - The flag clears in IDLE when m_lock_i[gnt]=0. A locked master issuing PINOOP keeps the lock.
- PI1R_LOCK_EN undefined:
  - There is no m_lock_i port and no lock flag.
  - Arbitration is pure round-robin every time.

## Structure
- Shared package pi1_pkg holds the op encodings (PINOOP..PIRWOP), the FSM state encodings and clog2. This package is shared with the other pi1 blocks.
- One sub-module, pi1r_rrpick: combinational round-robin picker.
  - Inputs: request vector and `last`.
  - Outputs: winner index and a valid flag.
  - Lock masking is applied before it.

## Test plan
- Reset with rst_i=0 mid-BUSY (s_op_o=PIRDOP) → all outputs 0 in the same cycle; after release, master 0 requesting PIWROP addr 0x10 appears on s_op_o one cycle later.
- MASTERCOUNT=4, all masters PIRDOP simultaneously, slave rdy after 2 cycles returning 0xA0+index → grant order 0,1,2,3,0; each m_data_o equals 0xA0+i with a single m_rdy_o[i] pulse.
- Master 1 PIRWOP addr 0x20 data 0x55, slave returns 0x33 → s_data_o=0x55, m_data_o=0x33 with m_rdy_o=4'b0010.
- s_rdy_i held high in IDLE with no requests → no m_rdy_o pulse, s_op_o stays PINOOP.
- PI1R_LOCK_EN: master 2 asserts lock over 3 reads while master 0 requests continuously → master 2 is served 3 times, then master 0 is granted in the first IDLE after m_lock_i[2] drops.
- Minimum latency: slave rdy in the first BUSY cycle → m_rdy_o at t+2; next request is granted at t+3.
